pipe_ctrl: RTL
==============

# pipe_ctrl

Stage-sequencing controller for the five-stage core. It drives the stage-register enables and flushes for IF/ID/EX/LS, and raises the one-shot redirect to the IFU. It inserts load-use bubbles, freezes the pipe while the LSU has a memory access outstanding, and counts stall and flush cycles for performance analysis. It sits beside the EXU and LSU and owns the `EX_reg_execute_enable` the EXU consumes.

## Interface
Parameters:
- `CNT_LEN`, 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ID_rs1`, `ID_rs2`  in  5  source registers of the instruction in decode.
- `ID_rs1_ren`, `ID_rs2_ren`  in  1  decode reads rs1 / rs2.
- `IF_ID_reg_inst_valid`  in  1  decode holds a valid instruction.
- `ID_EX_reg_decode_valid`  in  1  EX holds a valid instruction.
- `ID_EX_reg_rd`  in  5  EX destination.
- `ID_EX_reg_dest_wen`  in  1  EX writes rd.
- `ID_EX_reg_is_load`  in  1  EX instruction is a load (`load_sign` non-zero).
- `EX_MON_reg_Jump_flag`  in  1  EX resolves a taken jump, branch, ret or trap (combinational, already qualified by valid).
- `EX_LS_reg_execute_valid`  in  1  LS holds a valid instruction.
- `EX_LS_reg_is_mem`  in  1  LS instruction is a load or store.
- `ls_done`  in  1  LSU memory access completes this cycle.
- `IF_reg_fetch_enable`, `ID_reg_decode_enable`, `EX_reg_execute_enable`, `LS_reg_enable`  out  1  stage-register load enables.
- `ID_flush`, `EX_flush`  out  1  clear the valid bit of IF/ID and ID/EX at the next edge.
- `redirect_valid`  out  1  one-cycle pulse; IFU loads `EX_IF_reg_Jump_PC`.
- `stall_cnt`, `flush_cnt`  out  `CNT_LEN`  saturating performance counters.

## Operation
- FSM states are RUN, LSWAIT and REDIRECT. Reset state is RUN. On reset every counter is 0 and every registered output is 0.
- **LS-busy condition:** `mem_busy = EX_LS_reg_execute_valid & EX_LS_reg_is_mem & ~ls_done`.
- **Load-use condition:** `lu_hazard = ID_EX_reg_decode_valid & ID_EX_reg_is_load & ID_EX_reg_dest_wen & (ID_EX_reg_rd != 0) & IF_ID_reg_inst_valid & ((ID_rs1_ren & ID_rs1 == ID_EX_reg_rd) | (ID_rs2_ren & ID_rs2 == ID_EX_reg_rd))`.
- **RUN:**
  - If `mem_busy`: all four enables are 0 and the next state is LSWAIT. A pending jump is not acted on.
  - Else if `EX_MON_reg_Jump_flag`: all enables are 1, `ID_flush = EX_flush = 1`, `redirect_valid = 1`, and the next state is REDIRECT.
  - Else if `lu_hazard`: `IF_reg_fetch_enable = ID_reg_decode_enable = 0`, `EX_reg_execute_enable = LS_reg_enable = 1`, and `EX_flush = 1` (bubble inserted into EX).
  - Else: all enables are 1.
- **LSWAIT:** enables are 0 while `mem_busy`. In the cycle `ls_done` rises, the outputs are evaluated exactly as in RUN with `mem_busy = 0`, and the state follows those RUN rules. This covers a jump held in EX during the wait, which is redirected in that same cycle.
- **REDIRECT:** one cycle.
  - `ID_flush = 1`, to drop the wrong-path fetch already in flight.
  - `IF_reg_fetch_enable = 1`, `ID_reg_decode_enable = 1`.
  - `EX_reg_execute_enable = 1`, `LS_reg_enable = 1`.
  - `EX_MON_reg_Jump_flag` is ignored, because EX holds a flushed bubble.
  - The next state is RUN, or LSWAIT if `mem_busy`.
- **Priority:** mem_busy > jump > load-use. A jump and a load-use hazard in the same cycle resolve as a jump, and the hazard's decode instruction is flushed.
- **Counters:**
  - `stall_cnt` increments in every cycle `EX_reg_execute_enable == 0` or `lu_hazard` stalls decode.
  - `flush_cnt` increments on each `redirect_valid`.
  - Both counters saturate at all-ones and do not wrap.

## Timing
- All enable and flush outputs are combinational from the current state and inputs, with zero-cycle latency.
- `redirect_valid` is combinational. It is high for exactly one cycle per taken jump.
- The state register and counters update on the rising edge of `clk`.
- Asserting `rst_n` low mid-operation forces RUN and zeroes the counters immediately, without waiting for a clock edge.
- A jump costs 2 bubble cycles: the flushed ID/EX slot and the flushed IF/ID slot.
- A load-use hazard costs 1 bubble cycle.

## Structure
- State encodings (RUN=2'd0, LSWAIT=2'd1, REDIRECT=2'd2) go in the shared defines header as `PIPE_ST_*`.
- The hazard comparator is a natural sub-module, `hazard_detect`: purely combinational, producing `lu_hazard`.
- The counters use a small sub-module, `sat_counter`, instantiated twice.
- State flops use the existing asynchronous-reset D flip-flop primitive.

## Test plan
- **Load-use stall:** EX holds a load with rd=5 and decode reads rs1=5 → exactly 1 cycle with IF/ID enables 0 and `EX_flush = 1`, then normal flow. `stall_cnt` goes 0→1. With rd=0, no stall occurs.
- **Taken jump:** pulse Jump_flag for 1 cycle → `redirect_valid` high 1 cycle. `ID_flush` is high 2 consecutive cycles and `EX_flush` 1 cycle. `flush_cnt` goes to 1.
- **LSU wait:** the LS store has `ls_done` low for 3 cycles → all enables 0 for 3 cycles. On the 4th cycle (`ls_done = 1`) all enables return to 1. `stall_cnt` = 3.
- **Jump blocked by mem_busy:** Jump_flag is held during a 2-cycle LSU wait → no redirect during the wait. A single `redirect_valid` fires in the `ls_done` cycle. `flush_cnt` = 1.
- **Simultaneous events:** a jump and a load-use hazard arrive together → jump behaviour only. `stall_cnt` is unchanged.
- **Reset and saturation:** drop `rst_n` during REDIRECT → outputs return to their reset values and the state is RUN without a clock edge. With `CNT_LEN = 4`, 20 stalls give `stall_cnt = 15`.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline stage controller.
// Holds the FSM state encodings and the per-cycle control bundle.
package pipe_ctrl_pkg;

    localparam logic [1:0] PIPE_ST_RUN      = 2'd0;
    localparam logic [1:0] PIPE_ST_LSWAIT   = 2'd1;
    localparam logic [1:0] PIPE_ST_REDIRECT = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = PIPE_ST_RUN,
        ST_LSWAIT   = PIPE_ST_LSWAIT,
        ST_REDIRECT = PIPE_ST_REDIRECT
    } state_t;

    typedef struct packed {
        logic if_en;
        logic id_en;
        logic ex_en;
        logic ls_en;
        logic id_flush;
        logic ex_flush;
        logic redirect;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_dff.sv
// Asynchronous active-low reset D flip-flop, reset value zero.
// Ports: clk, rst_n, d[W] in; q[W] out.
module dff_ar #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator between the decode sources and the EX load.
// Ports: decode rs1/rs2 + read enables + valid, EX rd/wen/load/valid in; lu_hazard out.
module hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_ren,
    input  logic       id_rs2_ren,
    input  logic       ex_valid,
    input  logic [4:0] ex_rd,
    input  logic       ex_wen,
    input  logic       ex_is_load,
    output logic       lu_hazard
);

    logic ex_ld;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real producer, so rd=0 cannot create a hazard
    assign ex_ld   = ex_valid & ex_is_load & ex_wen & (ex_rd != 5'd0);
    assign rs1_hit = id_rs1_ren & (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_ren & (id_rs2 == ex_rd);

    assign lu_hazard = ex_ld & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
// Ports: clk, rst_n, inc in; count[W] out (sticks at all-ones).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   count <= '0;
        else if (inc && count != '1)  count <= count + ONE;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stage-sequencing controller: enables, flushes, redirect, perf counters.
// Ports: hazard/LS/jump status in; stage enables, flushes, redirect, counters out.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         ID_rs1,
    input  logic [4:0]         ID_rs2,
    input  logic               ID_rs1_ren,
    input  logic               ID_rs2_ren,
    input  logic               IF_ID_reg_inst_valid,
    input  logic               ID_EX_reg_decode_valid,
    input  logic [4:0]         ID_EX_reg_rd,
    input  logic               ID_EX_reg_dest_wen,
    input  logic               ID_EX_reg_is_load,
    input  logic               EX_MON_reg_Jump_flag,
    input  logic               EX_LS_reg_execute_valid,
    input  logic               EX_LS_reg_is_mem,
    input  logic               ls_done,
    output logic               IF_reg_fetch_enable,
    output logic               ID_reg_decode_enable,
    output logic               EX_reg_execute_enable,
    output logic               LS_reg_enable,
    output logic               ID_flush,
    output logic               EX_flush,
    output logic               redirect_valid,
    output logic [CNT_LEN-1:0] stall_cnt,
    output logic [CNT_LEN-1:0] flush_cnt
);

    logic       mem_busy;
    logic       lu_hazard;
    logic [1:0] state_q;
    state_t     state;
    state_t     nxt;
    ctrl_t      c;

    assign mem_busy = EX_LS_reg_execute_valid & EX_LS_reg_is_mem & ~ls_done;

    hazard_detect u_hazard (
        .id_valid   (IF_ID_reg_inst_valid),
        .id_rs1     (ID_rs1),
        .id_rs2     (ID_rs2),
        .id_rs1_ren (ID_rs1_ren),
        .id_rs2_ren (ID_rs2_ren),
        .ex_valid   (ID_EX_reg_decode_valid),
        .ex_rd      (ID_EX_reg_rd),
        .ex_wen     (ID_EX_reg_dest_wen),
        .ex_is_load (ID_EX_reg_is_load),
        .lu_hazard  (lu_hazard)
    );

    dff_ar #(.W(2)) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (nxt),
        .q     (state_q)
    );

    assign state = state_t'(state_q);

    // LSWAIT shares RUN's rules: once ls_done drops mem_busy, the
    // same priority chain decides, including a jump held in EX.
    always_comb begin
        c   = '0;
        nxt = ST_RUN;
        unique case (state)
            ST_RUN, ST_LSWAIT: begin
                if (mem_busy) begin
                    nxt = ST_LSWAIT;
                end else if (EX_MON_reg_Jump_flag) begin
                    c   = '1;
                    nxt = ST_REDIRECT;
                end else if (lu_hazard) begin
                    c.ex_en    = 1'b1;
                    c.ls_en    = 1'b1;
                    c.ex_flush = 1'b1;
                end else begin
                    c.if_en = 1'b1;
                    c.id_en = 1'b1;
                    c.ex_en = 1'b1;
                    c.ls_en = 1'b1;
                end
            end
            ST_REDIRECT: begin
                // EX holds a flushed bubble; only the wrong-path fetch is dropped
                c.if_en    = 1'b1;
                c.id_en    = 1'b1;
                c.ex_en    = 1'b1;
                c.ls_en    = 1'b1;
                c.id_flush = 1'b1;
                nxt        = mem_busy ? ST_LSWAIT : ST_RUN;
            end
            default: nxt = ST_RUN;
        endcase
    end

    assign IF_reg_fetch_enable   = c.if_en;
    assign ID_reg_decode_enable  = c.id_en;
    assign EX_reg_execute_enable = c.ex_en;
    assign LS_reg_enable         = c.ls_en;
    assign ID_flush              = c.id_flush;
    assign EX_flush              = c.ex_flush;
    assign redirect_valid        = c.redirect;

    // decode is held only by a freeze or by a load-use bubble
    sat_counter #(.W(CNT_LEN)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~c.ex_en | ~c.id_en),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_LEN)) u_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (c.redirect),
        .count (flush_cnt)
    );

endmodule
